// File: rtl/dmac_mc_master.sv
// Multi-channel AHB-Lite DMA master: NCH channel contexts share one bus port, round-robin, one read+write per grant.
// Latency: start -> busy next cycle -> RA one cycle later; zero-wait transfer = RA,RD,WA,WD,UPD plus one IDLE arbitration cycle.
// Backpressure: every AHB phase is held until HREADY; peripheral IRQ pacing gates the first transfer of each block.
module dmac_mc_master #(
    parameter int NCH  = 4,
    parameter int CW   = 16,
    parameter int NIRQ = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [31:0]       HRDATA,
    input  logic [NCH*32-1:0] saddr,
    input  logic [NCH*32-1:0] daddr,
    input  logic [NCH*3-1:0]  ssize,
    input  logic [NCH*3-1:0]  dsize,
    input  logic [NCH*3-1:0]  sinc,
    input  logic [NCH*3-1:0]  dinc,
    input  logic [NCH*CW-1:0] bsize,
    input  logic [NCH*CW-1:0] bcount,
    input  logic [NCH-1:0]    wfi,
    input  logic [NCH*3-1:0]  irqsrc,
    input  logic [NIRQ-1:0]   pirq,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    abort,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done,
    output logic [NCH-1:0]    err
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RA, S_RD, S_WA, S_WD, S_UPD, S_ERR} state_t;

    state_t          state;
    logic [IW-1:0]   own;
    logic [IW-1:0]   last;
    logic [31:0]     d;
    logic [31:0]     sa [NCH];
    logic [31:0]     da [NCH];
    logic [CW-1:0]   cb [NCH];
    logic [CW-1:0]   cr [NCH];
    logic [NCH-1:0]  abrt;
    logic [2:0]      s_sz [NCH];
    logic [2:0]      d_sz [NCH];
    logic [2:0]      s_inc [NCH];
    logic [2:0]      d_inc [NCH];
    logic [2:0]      src [NCH];
    logic [CW-1:0]   bs [NCH];
    logic [CW-1:0]   bc [NCH];
    logic [NCH-1:0]  irq_ok;
    logic [NCH-1:0]  elig;
    logic [NCH-1:0]  own_act;
    logic            gnt_vld;
    logic [IW-1:0]   gnt;

    assign HWDATA = d;

    // Place the addressed byte/half lane of a read beat on every lane.
    function automatic logic [31:0] align(input logic [31:0] x, input logic [2:0] sz, input logic [1:0] a);
        logic [31:0] r;
        logic [7:0]  b;
        logic [15:0] h;
        b = x[8*a +: 8];
        h = a[1] ? x[31:16] : x[15:0];
        case (sz)
            3'd0:    r = {4{b}};
            3'd1:    r = {2{h}};
            default: r = x;
        endcase
        return r;
    endfunction

    // Unpack per-channel fields and decide which channels may bid for the bus.
    always_comb begin
        irq_ok  = '0;
        elig    = '0;
        own_act = '0;
        done    = '0;
        for (int c = 0; c < NCH; c++) begin
            s_sz[c]  = ssize[3*c +: 3];
            d_sz[c]  = dsize[3*c +: 3];
            s_inc[c] = sinc[3*c +: 3];
            d_inc[c] = dinc[3*c +: 3];
            src[c]   = irqsrc[3*c +: 3];
            bs[c]    = bsize[CW*c +: CW];
            bc[c]    = bcount[CW*c +: CW];
            // An irqsrc beyond the pirq vector never matches, so it never paces through.
            for (int i = 0; i < NIRQ; i++) begin
                if (int'(src[c]) == i) irq_ok[c] = pirq[i];
            end
            elig[c]    = busy[c] & ~abrt[c] & ~abort[c] & (~wfi[c] | (cb[c] != bs[c]) | irq_ok[c]);
            own_act[c] = (state != S_IDLE) && (own == IW'(c));
            done[c]    = (state == S_UPD) && (own == IW'(c)) && !abrt[c] && (cb[c] == '0) && (cr[c] == '0);
        end
    end

    // Round-robin pick starting at the channel after the last grant.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(last) + k) % NCH;
            if (elig[idx]) begin
                gnt_vld = 1'b1;
                gnt     = IW'(idx);
            end
        end
    end

    // Channel contexts: start, abort, address/count update and error capture.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            busy <= '0;
            err  <= '0;
            abrt <= '0;
            for (int c = 0; c < NCH; c++) begin
                sa[c] <= '0;
                da[c] <= '0;
                cb[c] <= '0;
                cr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (start[c] && !busy[c]) begin
                    sa[c]   <= saddr[32*c +: 32];
                    da[c]   <= daddr[32*c +: 32];
                    cb[c]   <= bs[c];
                    cr[c]   <= bc[c];
                    busy[c] <= 1'b1;
                    err[c]  <= 1'b0;
                    abrt[c] <= 1'b0;
                end else if (busy[c]) begin
                    if (!own_act[c]) begin
                        // Not on the bus: an abort (new or left over from UPD) stops it now.
                        if (abort[c] || abrt[c]) begin
                            busy[c] <= 1'b0;
                            abrt[c] <= 1'b0;
                        end
                    end else begin
                        // Owner: remember the abort and let the bus phase in flight finish.
                        if (abort[c]) abrt[c] <= 1'b1;
                        if (state == S_UPD) begin
                            if (abrt[c]) begin
                                busy[c] <= 1'b0;
                                abrt[c] <= 1'b0;
                            end else begin
                                sa[c] <= sa[c] + 32'(s_inc[c]);
                                da[c] <= da[c] + 32'(d_inc[c]);
                                if (cb[c] != '0) begin
                                    cb[c] <= cb[c] - CW'(1);
                                end else if (cr[c] != '0) begin
                                    cr[c] <= cr[c] - CW'(1);
                                    cb[c] <= bs[c];
                                end else begin
                                    busy[c] <= 1'b0;
                                end
                            end
                        end else if (state == S_ERR) begin
                            err[c]  <= 1'b1;
                            busy[c] <= 1'b0;
                            abrt[c] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Bus engine: arbitrate in IDLE, then one read beat and one write beat for the owner.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state  <= S_IDLE;
            own    <= '0;
            last   <= IW'(NCH - 1);
            HTRANS <= 2'b00;
            HADDR  <= '0;
            HSIZE  <= 3'b010;
            HWRITE <= 1'b0;
            d      <= '0;
        end else begin
            case (state)
                S_IDLE: if (gnt_vld) begin
                    own    <= gnt;
                    last   <= gnt;
                    state  <= S_RA;
                    HTRANS <= 2'b10;
                    HADDR  <= sa[gnt];
                    HSIZE  <= s_sz[gnt];
                    HWRITE <= 1'b0;
                end
                S_RA: if (HREADY) begin
                    state  <= S_RD;
                    HTRANS <= 2'b00;
                end
                S_RD: if (HREADY) begin
                    if (HRESP) begin
                        state <= S_ERR;
                    end else begin
                        d <= align(HRDATA, s_sz[own], sa[own][1:0]);
                        // An aborted owner skips the write and retires through UPD.
                        if (abrt[own] || abort[own]) begin
                            state <= S_UPD;
                        end else begin
                            state  <= S_WA;
                            HTRANS <= 2'b10;
                            HADDR  <= da[own];
                            HSIZE  <= d_sz[own];
                            HWRITE <= 1'b1;
                        end
                    end
                end
                S_WA: if (HREADY) begin
                    state  <= S_WD;
                    HTRANS <= 2'b00;
                end
                S_WD: if (HREADY) begin
                    state <= HRESP ? S_ERR : S_UPD;
                end
                default: begin
                    state  <= S_IDLE;
                    HWRITE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_mc_master.sv
// Bench for dmac_mc_master: directed channel scenarios against a simple AHB slave.
// Expected bus beats are queued at stimulus time; a monitor pops and compares each completed beat.
// Slave inserts a programmable number of wait states per phase and can flag one read with ERROR.
module tb_dmac_mc_master;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int NIRQ = 8;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } xfer_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic HWRITE, HREADY, HRESP;
    logic [NCH*32-1:0] saddr, daddr;
    logic [NCH*3-1:0]  ssize, dsize, sinc, dinc, irqsrc;
    logic [NCH*CW-1:0] bsize, bcount;
    logic [NCH-1:0] wfi, start, abort, busy, done, err;
    logic [NIRQ-1:0] pirq;

    xfer_t expq[$];
    int total, bad, nxfer, rd_acc, rd_seen, ws, cnt, err_rd;
    int done_cnt[NCH];
    bit wa_seen, use_fixed;
    logic [31:0] fixed_val, last_rd_addr;

    always #5 HCLK = ~HCLK;

    assign HRDATA = use_fixed ? fixed_val : (last_rd_addr ^ 32'h5A5A0000);

    dmac_mc_master #(.NCH(NCH), .CW(CW), .NIRQ(NIRQ)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .saddr(saddr), .daddr(daddr), .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc),
        .bsize(bsize), .bcount(bcount), .wfi(wfi), .irqsrc(irqsrc), .pirq(pirq),
        .start(start), .abort(abort), .busy(busy), .done(done), .err(err)
    );

    function automatic xfer_t mk(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] dat);
        xfer_t x;
        x.wr = wr; x.addr = a; x.size = sz; x.data = dat;
        return x;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cfg(input int ch, input logic [31:0] sa, input logic [31:0] da, input logic [2:0] ss,
                       input logic [2:0] ds, input logic [2:0] si, input logic [2:0] di, input logic [15:0] bs,
                       input logic [15:0] bc, input logic w, input logic [2:0] irq);
        saddr[32*ch +: 32] = sa;  daddr[32*ch +: 32] = da;
        ssize[3*ch +: 3] = ss;    dsize[3*ch +: 3] = ds;
        sinc[3*ch +: 3] = si;     dinc[3*ch +: 3] = di;
        bsize[CW*ch +: CW] = bs;  bcount[CW*ch +: CW] = bc;
        wfi[ch] = w;              irqsrc[3*ch +: 3] = irq;
    endtask

    // Queue a word copy beat pair; read data is the slave's address pattern.
    task automatic push_word(input logic [31:0] s, input logic [31:0] d);
        expq.push_back(mk(1'b0, s, 3'd2, 32'h0));
        expq.push_back(mk(1'b1, d, 3'd2, s ^ 32'h5A5A0000));
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m);
        start = m;
        tick();
        start = '0;
    endtask

    task automatic wait_idle(input logic [NCH-1:0] m, input int lim, input string nm);
        int k = 0;
        while (((busy & m) != '0) && (k < lim)) begin
            tick();
            k++;
        end
        chk(nm, 32'(busy & m), 32'h0);
    endtask

    task automatic do_reset();
        start = '0; abort = '0; pirq = '0; ws = 0; err_rd = 0; use_fixed = 1'b0;
        expq.delete();
        HRESETn = 1'b0;
        tick(); tick();
        HRESETn = 1'b1;
        tick();
    endtask

    // Bus monitor: a beat completes when its data phase sees HREADY; compare with the queue head.
    task automatic monitor();
        xfer_t cur, e;
        bit pend = 1'b0;
        forever begin
            @(negedge HCLK);
            wa_seen = (HTRANS == 2'b10) && HWRITE;
            if (!HRESETn) begin
                pend = 1'b0;
            end else begin
                for (int c = 0; c < NCH; c++) if (done[c]) done_cnt[c]++;
                if (pend && HREADY) begin
                    pend = 1'b0;
                    if (cur.wr) cur.data = HWDATA;
                    nxfer++;
                    total++;
                    if (expq.size() == 0) begin
                        bad++;
                        $display("FAIL xfer_unexpected got=%h want=none", cur);
                    end else begin
                        e = expq.pop_front();
                        if (cur !== e) begin
                            bad++;
                            $display("FAIL xfer got=%h want=%h", cur, e);
                        end
                    end
                end
                if ((HTRANS == 2'b10) && HREADY) begin
                    pend = 1'b1;
                    cur = mk(HWRITE, HADDR, HSIZE, 32'h0);
                    if (!HWRITE) begin
                        last_rd_addr = HADDR;
                        rd_acc++;
                    end
                end
            end
        end
    endtask

    // Slave: ws wait states after every completed phase; ERROR on the read numbered err_rd.
    task automatic slave();
        forever begin
            tick();
            HRESP = 1'b0;
            if (rd_acc != rd_seen) begin
                rd_seen = rd_acc;
                if (rd_acc == err_rd) HRESP = 1'b1;
            end
            if (HREADY) cnt = ws;
            if (cnt == 0) HREADY = 1'b1;
            else begin
                HREADY = 1'b0;
                cnt--;
            end
        end
    endtask

    task automatic stimulus();
        int n0, r0, d0, d2, k;
        saddr = '0; daddr = '0; ssize = '0; dsize = '0; sinc = '0; dinc = '0;
        bsize = '0; bcount = '0; wfi = '0; irqsrc = '0;

        // Reset state
        do_reset();
        @(negedge HCLK);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_htrans", 32'(HTRANS), 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", 32'(HWRITE), 0);
        chk("rst_hsize", 32'(HSIZE), 2);
        chk("rst_hwdata", HWDATA, 0);

        // Ch0 word copy: 2 blocks of 4
        cfg(0, 32'h100, 32'h200, 2, 2, 4, 4, 3, 1, 0, 0);
        for (int i = 0; i < 8; i++) push_word(32'h100 + 4*i, 32'h200 + 4*i);
        d0 = done_cnt[0]; n0 = nxfer;
        pulse_start(4'b0001);
        @(negedge HCLK);
        chk("lat_busy", 32'(busy[0]), 1);
        chk("lat_idle", 32'(HTRANS), 0);
        @(negedge HCLK);
        chk("lat_ra_htrans", 32'(HTRANS), 2);
        chk("lat_ra_haddr", HADDR, 32'h100);
        wait_idle(4'b0001, 300, "copy_busy");
        chk("copy_done", done_cnt[0] - d0, 1);
        chk("copy_beats", nxfer - n0, 16);
        chk("copy_left", expq.size(), 0);

        // Ch0 and ch2 together: grants alternate
        do_reset();
        cfg(0, 32'h1000, 32'h1800, 2, 2, 4, 4, 1, 0, 0, 0);
        cfg(2, 32'h3000, 32'h3800, 2, 2, 4, 4, 1, 0, 0, 0);
        push_word(32'h1000, 32'h1800); push_word(32'h3000, 32'h3800);
        push_word(32'h1004, 32'h1804); push_word(32'h3004, 32'h3804);
        d0 = done_cnt[0]; d2 = done_cnt[2];
        pulse_start(4'b0101);
        wait_idle(4'b0101, 300, "rr_busy");
        chk("rr_done0", done_cnt[0] - d0, 1);
        chk("rr_done2", done_cnt[2] - d2, 1);
        chk("rr_left", expq.size(), 0);

        // Byte and halfword lane replication
        do_reset();
        use_fixed = 1'b1; fixed_val = 32'hAABBCCDD;
        cfg(1, 32'h103, 32'h201, 0, 0, 1, 1, 0, 0, 0, 0);
        expq.push_back(mk(1'b0, 32'h103, 3'd0, 32'h0));
        expq.push_back(mk(1'b1, 32'h201, 3'd0, 32'hAAAAAAAA));
        pulse_start(4'b0010);
        wait_idle(4'b0010, 100, "byte_busy");
        cfg(1, 32'h102, 32'h402, 1, 1, 2, 2, 0, 0, 0, 0);
        expq.push_back(mk(1'b0, 32'h102, 3'd1, 32'h0));
        expq.push_back(mk(1'b1, 32'h402, 3'd1, 32'hAABBAABB));
        pulse_start(4'b0010);
        wait_idle(4'b0010, 100, "half_busy");
        chk("lane_left", expq.size(), 0);
        use_fixed = 1'b0;

        // IRQ pacing on ch3 via pirq[5]
        do_reset();
        cfg(3, 32'h500, 32'h600, 2, 2, 4, 4, 1, 1, 1, 5);
        for (int i = 0; i < 4; i++) push_word(32'h500 + 4*i, 32'h600 + 4*i);
        d0 = done_cnt[3]; n0 = nxfer; r0 = rd_acc;
        pulse_start(4'b1000);
        for (int i = 0; i < 20; i++) tick();
        chk("wfi_hold", nxfer - n0, 0);
        chk("wfi_hold_busy", 32'(busy[3]), 1);
        pirq[5] = 1'b1;
        k = 0;
        while ((rd_acc == r0) && (k < 50)) begin tick(); k++; end
        pirq[5] = 1'b0;
        k = 0;
        while ((nxfer < n0 + 4) && (k < 100)) begin tick(); k++; end
        for (int i = 0; i < 20; i++) tick();
        chk("wfi_gap", nxfer - n0, 4);
        chk("wfi_gap_busy", 32'(busy[3]), 1);
        pirq[5] = 1'b1;
        wait_idle(4'b1000, 200, "wfi_busy");
        chk("wfi_beats", nxfer - n0, 8);
        chk("wfi_done", done_cnt[3] - d0, 1);
        chk("wfi_left", expq.size(), 0);
        pirq = '0;

        // Bus error on the second read
        do_reset();
        cfg(1, 32'h700, 32'h780, 2, 2, 4, 4, 3, 0, 0, 0);
        push_word(32'h700, 32'h780);
        expq.push_back(mk(1'b0, 32'h704, 3'd2, 32'h0));
        err_rd = rd_acc + 2;
        d0 = done_cnt[1];
        pulse_start(4'b0010);
        wait_idle(4'b0010, 200, "err_busy");
        tick();
        chk("err_flag", 32'(err[1]), 1);
        chk("err_done", done_cnt[1] - d0, 0);
        chk("err_left", expq.size(), 0);
        err_rd = 0;
        cfg(1, 32'h700, 32'h780, 2, 2, 4, 4, 0, 0, 0, 0);
        push_word(32'h700, 32'h780);
        pulse_start(4'b0010);
        @(negedge HCLK);
        chk("err_clear", 32'(err[1]), 0);
        wait_idle(4'b0010, 100, "err_restart_busy");
        chk("err_restart_left", expq.size(), 0);

        // Abort of the owner during WA with 3 wait states
        do_reset();
        ws = 3;
        cfg(1, 32'h900, 32'h980, 2, 2, 4, 4, 3, 0, 0, 0);
        push_word(32'h900, 32'h980);
        d0 = done_cnt[1]; n0 = nxfer;
        pulse_start(4'b0010);
        k = 0;
        while (!wa_seen && (k < 100)) begin tick(); k++; end
        abort = 4'b0010;
        tick();
        abort = '0;
        wait_idle(4'b0010, 100, "abort_busy");
        for (int i = 0; i < 30; i++) tick();
        chk("abort_beats", nxfer - n0, 2);
        chk("abort_done", done_cnt[1] - d0, 0);
        chk("abort_left", expq.size(), 0);

        // Abort of a waiting non-owner clears busy next cycle
        ws = 0;
        cfg(2, 32'hA00, 32'hB00, 2, 2, 4, 4, 0, 0, 1, 5);
        pulse_start(4'b0100);
        @(negedge HCLK);
        chk("nabort_pre", 32'(busy[2]), 1);
        abort = 4'b0100;
        tick();
        abort = '0;
        @(negedge HCLK);
        chk("nabort_post", 32'(busy[2]), 0);

        // Reset during a stalled RD
        do_reset();
        ws = 3;
        cfg(0, 32'hC00, 32'hD00, 2, 2, 4, 4, 3, 0, 0, 0);
        n0 = nxfer; r0 = rd_acc;
        pulse_start(4'b0001);
        k = 0;
        while ((rd_acc == r0) && (k < 100)) begin tick(); k++; end
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("mrst_htrans", 32'(HTRANS), 0);
        chk("mrst_busy", 32'(busy), 0);
        ws = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("mrst_beats", nxfer - n0, 0);
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        start = '0; abort = '0; pirq = '0;
        total = 0; bad = 0; nxfer = 0; rd_acc = 0; rd_seen = 0; ws = 0; cnt = 0; err_rd = 0;
        wa_seen = 1'b0; use_fixed = 1'b0; fixed_val = '0; last_rd_addr = '0;
        for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
        fork
            monitor();
            slave();
            stimulus();
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
